// File: rtl/axis_dwidth_pkg.sv
// Shared constants and helpers for the AXI4-Stream width upsizer.
package axis_dwidth_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_NUM_REG = 2;

  function automatic int cnt_width(input int num_reg);
    return (num_reg > 1) ? $clog2(num_reg) : 1;
  endfunction

endpackage

// File: rtl/axis_dwidth_upsize.sv
// AXI4-Stream upsizer: packs NUM_REG narrow slave beats into one wide master beat,
// least-significant lane first; an early tlast flushes a zero-filled partial word.
module axis_dwidth_upsize
  import axis_dwidth_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NUM_REG = DEFAULT_NUM_REG
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [WIDTH-1:0]         s_axis_tdata,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [WIDTH*NUM_REG-1:0] m_axis_tdata,
  output logic                     m_axis_tlast
);

  localparam int            CW        = cnt_width(NUM_REG);
  localparam int            MW        = WIDTH * NUM_REG;
  localparam logic [CW-1:0] LAST_LANE = CW'(NUM_REG - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] lanes_q, lanes_d;
  logic [MW-1:0] m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;

  logic [MW-1:0] word_s;
  logic          s_ready_s;
  logic          s_accept_s;
  logic          m_xfer_s;
  logic          complete_s;

  // Ready depends only on the output register and downstream ready, never on s_axis_tvalid.
  assign s_ready_s  = aresetn & (~m_valid_q | m_axis_tready);
  assign s_accept_s = s_axis_tvalid & s_ready_s;
  assign m_xfer_s   = m_valid_q & m_axis_tready;
  assign complete_s = (cnt_q == LAST_LANE) | s_axis_tlast;

  always_comb begin
    word_s                        = lanes_q;
    word_s[cnt_q*WIDTH +: WIDTH]  = s_axis_tdata;

    cnt_d     = cnt_q;
    lanes_d   = lanes_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q & ~m_xfer_s;

    if (s_accept_s) begin
      if (complete_s) begin
        // Completing beat bypasses the lane registers straight into the output word.
        m_data_d  = word_s;
        m_last_d  = s_axis_tlast;
        m_valid_d = 1'b1;
        cnt_d     = {CW{1'b0}};
        lanes_d   = {MW{1'b0}};
      end else begin
        lanes_d = word_s;
        cnt_d   = cnt_q + CW'(1);
      end
    end else begin
      cnt_d   = cnt_q;
      lanes_d = lanes_q;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q     <= {CW{1'b0}};
      lanes_q   <= {MW{1'b0}};
      m_data_q  <= {MW{1'b0}};
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      lanes_q   <= lanes_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  assign s_axis_tready = s_ready_s;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_axis_dwidth_upsize.sv
// Directed and randomised self-checking bench for axis_dwidth_upsize (WIDTH=32, NUM_REG=2).
module tb_axis_dwidth_upsize;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = 32'd0;
  logic        s_axis_tlast = 1'b0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [64:0] exp_q[$];
  logic [64:0] e_w;
  logic        use_model = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_word = 64'd0;

  axis_dwidth_upsize #(.WIDTH(32), .NUM_REG(2)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int   n = 0;
    logic acc;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    do begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk);
      #1;
      n++;
    end while (!acc && n < 20);
    check_eq("send_accept", 65'(acc), 65'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check_eq({tag, "_drain"}, 65'(exp_q.size()), 65'd0);
    repeat (2) tick();
    check_eq({tag, "_idle_valid"}, 65'(m_axis_tvalid), 65'd0);
  endtask

  // Scoreboard: every master transfer must match the oldest expected word; random phase also models packing.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 65'(exp_q.size()), 65'd1);
        end else begin
          e_w = exp_q.pop_front();
          check_eq("m_tdata", 65'(m_axis_tdata), 65'(e_w[63:0]));
          check_eq("m_tlast", 65'(m_axis_tlast), 65'(e_w[64]));
        end
      end
      if (use_model && s_axis_tvalid && s_axis_tready) begin
        m_word[m_cnt*32 +: 32] = s_axis_tdata;
        if (m_cnt == 1 || s_axis_tlast) begin
          exp_q.push_back({s_axis_tlast, m_word});
          m_word = 64'd0;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  initial begin
    int   sent;
    int   cyc;
    logic acc;

    // Reset pulse and reset-state checks
    #50;
    check_eq("rst_s_tready", 65'(s_axis_tready), 65'd0);
    check_eq("rst_m_tvalid", 65'(m_axis_tvalid), 65'd0);
    check_eq("rst_m_tdata",  65'(m_axis_tdata),  65'd0);
    check_eq("rst_m_tlast",  65'(m_axis_tlast),  65'd0);
    tick();
    aresetn = 1'b1;
    tick();

    // Constant 0x64 stream, ready held high
    repeat (3) exp_q.push_back({1'b0, 64'h00000064_00000064});
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'd100;
    s_axis_tlast  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("const_s_tready", 65'(s_axis_tready), 65'd1);
      check_eq("const_m_tvalid", 65'(m_axis_tvalid), 65'(i % 2 == 1));
      if (i == 5) s_axis_tvalid = 1'b0;
    end
    drain("const");

    // Incrementing data with latency check
    exp_q.push_back({1'b0, 64'h00000002_00000001});
    exp_q.push_back({1'b0, 64'h00000004_00000003});
    send(32'd1, 1'b0);
    check_eq("inc_valid_after_b1", 65'(m_axis_tvalid), 65'd0);
    send(32'd2, 1'b0);
    check_eq("inc_valid_after_b2", 65'(m_axis_tvalid), 65'd1);
    check_eq("inc_data_after_b2",  65'(m_axis_tdata), 65'h00000002_00000001);
    send(32'd3, 1'b0);
    send(32'd4, 1'b0);
    drain("inc");

    // Early tlast flushes zero-filled word; next beat restarts at lane 0
    exp_q.push_back({1'b0, 64'h00000002_00000001});
    exp_q.push_back({1'b1, 64'h00000000_00000003});
    exp_q.push_back({1'b0, 64'h00000008_00000007});
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    check_eq("tlast_data", 65'(m_axis_tdata), 65'h00000000_00000003);
    check_eq("tlast_flag", 65'(m_axis_tlast), 65'd1);
    send(32'd7, 1'b0);
    send(32'd8, 1'b0);
    drain("tlast");

    // Backpressure: output full, downstream stalled for 5 cycles
    exp_q.push_back({1'b0, 64'h0000000A_00000009});
    exp_q.push_back({1'b0, 64'h0000000C_0000000B});
    m_axis_tready = 1'b0;
    send(32'd9, 1'b0);
    send(32'd10, 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'd11;
    s_axis_tlast  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_s_tready", 65'(s_axis_tready), 65'd0);
      check_eq("stall_m_tvalid", 65'(m_axis_tvalid), 65'd1);
      check_eq("stall_m_tdata",  65'(m_axis_tdata),  65'h0000000A_00000009);
      tick();
    end
    m_axis_tready = 1'b1;
    send(32'd11, 1'b0);
    send(32'd12, 1'b0);
    drain("stall");

    // Reset with a full pending word, then reset with a half-filled word
    m_axis_tready = 1'b0;
    send(32'h20, 1'b0);
    send(32'h21, 1'b0);
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    check_eq("mrst_s_tready", 65'(s_axis_tready), 65'd0);
    check_eq("mrst_m_tvalid", 65'(m_axis_tvalid), 65'd0);
    check_eq("mrst_m_tdata",  65'(m_axis_tdata),  65'd0);
    check_eq("mrst_m_tlast",  65'(m_axis_tlast),  65'd0);
    tick();
    tick();
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    send(32'h30, 1'b0);
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    check_eq("prst_s_tready", 65'(s_axis_tready), 65'd0);
    tick();
    aresetn = 1'b1;
    tick();
    exp_q.push_back({1'b0, 64'h00000006_00000005});
    send(32'd5, 1'b0);
    send(32'd6, 1'b0);
    check_eq("prst_m_tdata", 65'(m_axis_tdata), 65'h00000006_00000005);
    drain("prst");

    // Random valid/ready toggling with random tlast, 1000 beats
    m_cnt     = 0;
    m_word    = 64'd0;
    use_model = 1'b1;
    sent      = 0;
    cyc       = 0;
    s_axis_tvalid = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      if (!s_axis_tvalid && $urandom_range(0, 3) != 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = $urandom;
        s_axis_tlast  = (sent == 999) || ($urandom_range(0, 4) == 0);
      end
      if (!s_axis_tvalid) s_axis_tdata = $urandom;
      m_axis_tready = ($urandom_range(0, 3) != 0);
      @(negedge aclk);
      acc = s_axis_tvalid && s_axis_tready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        s_axis_tvalid = 1'b0;
      end
    end
    check_eq("rand_beats_sent", 65'(sent), 65'd1000);
    drain("rand");
    check_eq("rand_model_lane", 65'(m_cnt), 65'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_dwidth_upsize.md
Name: axis_dwidth_upsize

Overview:
- AXI4-Stream data-width upsizer that packs NUM_REG consecutive WIDTH-bit slave beats into one WIDTH*NUM_REG-bit master beat.
- Sits between a narrow stream producer and a wide stream consumer.
- Respects tready/tvalid on both sides and carries tlast through.
- An early tlast flushes a partially filled word.

Parameters:
- WIDTH, 32, slave data width in bits (>=8).
- NUM_REG, 2, upsizing ratio; master width = WIDTH*NUM_REG (>=2).

Ports:
- aclk  input  1  clock; all logic on rising edge.
- aresetn  input  1  asynchronous, active-low reset.
- s_axis_tvalid  input  1  slave beat valid.
- s_axis_tready  output  1  upsizer can accept a slave beat.
- s_axis_tdata  input  WIDTH  slave data.
- s_axis_tlast  input  1  last beat of packet.
- m_axis_tvalid  output  1  wide beat valid.
- m_axis_tready  input  1  downstream accepts wide beat.
- m_axis_tdata  output  WIDTH*NUM_REG  packed data.
- m_axis_tlast  output  1  wide beat contains the packet's last slave beat.

Behaviour:
- Reset, asynchronous on aresetn low:
  - lane counter = 0; lane registers = 0.
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0.
  - s_axis_tready forced 0 while aresetn is low.
  - A reset mid-packet discards all partial data; no output beat is produced for it.
- Handshake:
  - s_axis_tready = aresetn & (~m_axis_tvalid | m_axis_tready).
  - Slave accept = s_axis_tvalid & s_axis_tready.
  - Master transfer = m_axis_tvalid & m_axis_tready.
  - No combinational path from s_axis_tvalid/s_axis_tlast to s_axis_tready.
- Packing:
  - The beat accepted at lane counter k goes to bits [k*WIDTH +: WIDTH].
  - The first beat of a word lands in the least-significant lane.
  - The counter increments per accept and wraps to 0 after lane NUM_REG-1.
- Word completion: an accept with counter == NUM_REG-1 or s_axis_tlast = 1 completes the word. On the next edge:
  - m_axis_tdata = assembled lanes, including the current beat written directly.
  - m_axis_tvalid = 1.
  - m_axis_tlast = s_axis_tlast.
  - Counter and lane registers cleared to 0.
- Early tlast (counter < NUM_REG-1): unfilled upper lanes output as 0.
- Output hold:
  - m_axis_tvalid stays 1 and m_axis_tdata/m_axis_tlast stay stable until a master transfer.
  - On a transfer with no simultaneous completion, m_axis_tvalid -> 0 next edge.
  - Simultaneous master transfer and new word completion: the output register loads the new word; m_axis_tvalid stays 1.
- Latency: m_axis_tvalid rises one cycle after the completing slave accept.
- Throughput: with m_axis_tready held 1, one slave beat per cycle sustained; one master beat every NUM_REG cycles.
- Backpressure: with m_axis_tready = 0 and output full, s_axis_tready = 0. No data loss, no duplication.
- s_axis_tdata is ignored when no accept occurs.

Decomposition:
- Package axis_dwidth_pkg:
  - default constants DEFAULT_WIDTH = 32, DEFAULT_NUM_REG = 2;
  - counter width function $clog2(NUM_REG).
- No sub-module needed. Lane registers, counter and output register live in one module.

Test Plan:
- Reset pulse (aresetn low 50 ns), then s_axis_tvalid = 1, tdata = 100 (0x64) constant, tlast = 0, m_axis_tready = 1 -> m_axis_tdata = 0x00000064_00000064 with m_axis_tvalid high every 2nd cycle; s_axis_tready constantly 1 after reset; m_axis_tlast = 0.
- Incrementing data 1, 2, 3, 4 -> beats 0x00000002_00000001 then 0x00000004_00000003; first valid one cycle after beat 2 is accepted.
- tlast on beat 3 of stream 1, 2, 3 -> 0x00000002_00000001 (tlast = 0), then 0x00000000_00000003 (tlast = 1); counter restarts at lane 0 for the next beat.
- m_axis_tready = 0 for 5 cycles with output full -> s_axis_tready = 0 for those cycles; m_axis_tdata stable; after release every word delivered exactly once, in order.
- Assert aresetn low after one beat (counter = 1) -> all outputs 0 immediately; next beats 5, 6 produce 0x00000006_00000005 with no residue from the aborted word.
- Random valid/ready toggling, 1000 beats, random tlast -> scoreboard matches lane order, zero fill and tlast on every master beat.
